// File: rtl/csa_accumulator.sv
// csa_accumulator: multi-operand adder fed by a carry-save compressor.
// Operands are absorbed into a redundant (sum, carry) pair at one per cycle.
// At frame end the pair is resolved chunk by chunk into a binary result,
// which is then offered on a valid/ready output.
module csa_accumulator #(
   parameter int BITS     = 8,
   parameter int ACC_BITS = 16,
   parameter int CHUNK    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITS-1:0]     in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_BITS-1:0] out_data,
   output logic [7:0]          out_count
);

   localparam int N  = ACC_BITS / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_ACC     = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   // Bitwise majority: the carry generated by a 3:2 compressor column.
   function automatic logic [ACC_BITS-1:0] majority(
      input logic [ACC_BITS-1:0] a,
      input logic [ACC_BITS-1:0] b,
      input logic [ACC_BITS-1:0] d
   );
      majority = (a & b) | (a & d) | (b & d);
   endfunction

   state_t              state_r;
   logic [ACC_BITS-1:0] s_r;
   logic [ACC_BITS-1:0] c_r;
   logic [ACC_BITS-1:0] result_r;
   logic [7:0]          count_r;
   logic [KW-1:0]       k_r;
   logic                cy_r;
   logic                in_ready_r;
   logic                out_valid_r;
   logic [ACC_BITS-1:0] out_data_r;
   logic [7:0]          out_count_r;

   logic [ACC_BITS-1:0] x_s;
   logic [ACC_BITS-1:0] maj_s;
   logic [CHUNK:0]      chunk_sum_s;
   logic [ACC_BITS-1:0] result_next_s;
   logic [7:0]          count_next_s;
   logic                accept_s;
   logic                last_chunk_s;

   // Datapath helpers: compressor terms, current chunk add and saturating count.
   always_comb begin
      x_s           = ACC_BITS'(in_data);
      maj_s         = majority(s_r, c_r, x_s);
      chunk_sum_s   = {1'b0, s_r[k_r*CHUNK +: CHUNK]}
                    + {1'b0, c_r[k_r*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cy_r};
      result_next_s = result_r;
      result_next_s[k_r*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
      accept_s      = in_valid && in_ready_r;
      last_chunk_s  = (k_r == KW'(N - 1));
      if (count_r == 8'd255) begin
         count_next_s = 8'd255;
      end else begin
         count_next_s = count_r + 8'd1;
      end
   end

   // Control FSM with redundant accumulator, resolver and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_ACC;
         s_r         <= {ACC_BITS{1'b0}};
         c_r         <= {ACC_BITS{1'b0}};
         result_r    <= {ACC_BITS{1'b0}};
         count_r     <= 8'd0;
         k_r         <= {KW{1'b0}};
         cy_r        <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_data_r  <= {ACC_BITS{1'b0}};
         out_count_r <= 8'd0;
      end else begin
         case (state_r)
            ST_ACC: begin
               if (accept_s) begin
                  s_r     <= s_r ^ c_r ^ x_s;
                  c_r     <= {maj_s[ACC_BITS-2:0], 1'b0};
                  count_r <= count_next_s;
                  if (in_last) begin
                     state_r    <= ST_RESOLVE;
                     k_r        <= {KW{1'b0}};
                     cy_r       <= 1'b0;
                     in_ready_r <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               result_r <= result_next_s;
               cy_r     <= chunk_sum_s[CHUNK];
               k_r      <= k_r + KW'(1);
               if (last_chunk_s) begin
                  // Final carry-out is dropped: result is modulo 2^ACC_BITS.
                  state_r     <= ST_OUT;
                  out_valid_r <= 1'b1;
                  out_data_r  <= result_next_s;
                  out_count_r <= count_r;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  state_r     <= ST_ACC;
                  s_r         <= {ACC_BITS{1'b0}};
                  c_r         <= {ACC_BITS{1'b0}};
                  count_r     <= 8'd0;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_ACC;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_count = out_count_r;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: table of directed frames plus
// hand-written sequences for reset, long frames, backpressure and abort.
module tb_csa_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_count;

   int checks = 0;
   int errors = 0;

   csa_accumulator #(.BITS(8), .ACC_BITS(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]      n;
      logic [3:0][7:0] ops;
      logic [15:0]     exp_data;
      logic [7:0]      exp_count;
   } vec_t;

   vec_t vecs [6];
   logic [7:0] op_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send op_q as one frame (optional random gaps), last op carries in_last.
   task automatic send_frame(input bit gaps);
      for (int i = 0; i < op_q.size(); i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               tick();
            end
         end
         chk("in_ready_during_frame", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b1;
         in_data  = op_q[i];
         in_last  = (i == op_q.size() - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for out_valid with a cycle budget and check the latency.
   task automatic wait_out();
      int edges;
      edges = 0;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
      end
      chk("latency", edges, 32'd4);
   endtask

   // Full frame with out_ready held high: result, pulse width, bubble.
   task automatic run_frame(input string name, input logic [15:0] ed, input logic [7:0] ec, input bit gaps);
      logic [15:0] held;
      out_ready = 1'b1;
      send_frame(gaps);
      wait_out();
      chk({name, "_data"}, {16'd0, out_data}, {16'd0, ed});
      chk({name, "_count"}, {24'd0, out_count}, {24'd0, ec});
      chk({name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
      held = out_data;
      tick();
      chk({name, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
      chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
      chk({name, "_data_held"}, {16'd0, out_data}, {16'd0, held});
   endtask

   initial begin
      vecs[0] = '{n: 3'd3, ops: {8'h00, 8'h30, 8'h20, 8'h10}, exp_data: 16'h0060, exp_count: 8'd3};
      vecs[1] = '{n: 3'd1, ops: {8'h00, 8'h00, 8'h00, 8'hAB}, exp_data: 16'h00AB, exp_count: 8'd1};
      vecs[2] = '{n: 3'd4, ops: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_data: 16'h03FC, exp_count: 8'd4};
      vecs[3] = '{n: 3'd2, ops: {8'h00, 8'h00, 8'h80, 8'h80}, exp_data: 16'h0100, exp_count: 8'd2};
      vecs[4] = '{n: 3'd3, ops: {8'h00, 8'h01, 8'hF0, 8'h0F}, exp_data: 16'h0100, exp_count: 8'd3};
      vecs[5] = '{n: 3'd4, ops: {8'h04, 8'h03, 8'h02, 8'h01}, exp_data: 16'h000A, exp_count: 8'd4};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // Reset with random inputs toggling.
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'($urandom);
         in_data   = 8'($urandom);
         in_last   = 1'($urandom);
         out_ready = 1'($urandom);
         tick();
      end
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_out_count", {24'd0, out_count}, 32'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b1;
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Table-driven frames.
      for (int v = 0; v < 6; v++) begin
         op_q.delete();
         for (int i = 0; i < int'(vecs[v].n); i++) op_q.push_back(vecs[v].ops[i]);
         run_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_count, 1'b0);
      end

      // 300 x 0xFF with random gaps: sum wraps, count saturates.
      op_q.delete();
      for (int i = 0; i < 300; i++) op_q.push_back(8'hFF);
      run_frame("long", 16'h2AD4, 8'd255, 1'b1);

      // Backpressure: result held for 10 cycles, inputs ignored.
      out_ready = 1'b0;
      op_q.delete();
      op_q.push_back(8'hFF);
      op_q.push_back(8'h01);
      send_frame(1'b0);
      wait_out();
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
            if (out_valid !== 1'b1 || out_data !== 16'h0100 || in_ready !== 1'b0
                || out_count !== 8'd2) bad++;
         end
         chk("bp_stable_cycles_bad", bad, 32'd0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;

      // Follow-up frame proves OUT-cycle pulses were ignored.
      op_q.delete();
      op_q.push_back(8'h11);
      op_q.push_back(8'h22);
      run_frame("after_bp", 16'h0033, 8'd2, 1'b0);

      // Reset two cycles into RESOLVE: no result escapes.
      op_q.delete();
      op_q.push_back(8'h33);
      op_q.push_back(8'h44);
      send_frame(1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_valid_in_reset", {31'd0, out_valid}, 32'd0);
      chk("abort_data_in_reset", {16'd0, out_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
         end
         chk("abort_no_out_valid", seen, 32'd0);
      end
      op_q.delete();
      op_q.push_back(8'h05);
      op_q.push_back(8'h07);
      run_frame("after_abort", 16'h000C, 8'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Sequential multi-operand adder that sits directly downstream of the carry-save compressor stage. It absorbs a stream of unsigned operands in redundant (sum, carry) form at one operand per cycle with no carry propagation. On the last operand of a frame it resolves the redundant pair into a binary result with a chunked carry-propagate pass, then presents the result on a valid/ready output.

## Interface
Parameters:
- BITS, 8, operand width.
- ACC_BITS, 16, accumulator and result width; ACC_BITS >= BITS.
- CHUNK, 4, bits resolved per cycle; ACC_BITS must be a multiple of CHUNK. N = ACC_BITS/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  BITS  unsigned operand, zero-extended to ACC_BITS.
- in_last  input  1  marks the final operand of a frame; qualified by the handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  ACC_BITS  frame sum mod 2^ACC_BITS.
- out_count  output  8  operands in the frame, saturating at 255.

## Operation
States: ACC, RESOLVE, OUT.
- Reset value: state ACC; internal s, c, result and count all 0. Outputs: out_valid=0, out_data=0, out_count=0. in_ready=1 once rst_n deasserts.
- in_ready = (state == ACC). out_valid = (state == OUT). Both are decoded from registered state only, with no combinational path from the inputs.
- ACC: on in_valid && in_ready:
  - x = zero-extended in_data.
  - s <= s ^ c ^ x.
  - c <= (majority(s, c, x) << 1), truncated to ACC_BITS; bit 0 = 0.
  - count <= min(count+1, 255).
  - If in_last, go to RESOLVE with chunk index k=0 and carry register cy=0.
  - Cycles with in_valid=0 leave all state unchanged.
- RESOLVE: one chunk per cycle, LSB chunk first.
  - {cy, result[k*CHUNK +: CHUNK]} <= s[k*CHUNK +: CHUNK] + c[k*CHUNK +: CHUNK] + cy.
  - k increments. After chunk N-1, go to OUT.
  - The final carry-out is discarded (modulo arithmetic).
  - in_valid and out_ready are ignored.
- OUT: out_data = result, out_count = count; both are held stable while out_valid=1.
  - On out_ready: clear s, c and count, go to ACC. out_data and out_count keep their last values until the next OUT.
- Invariant: s + c mod 2^ACC_BITS always equals the running sum of accepted operands.

## Timing
- Throughput in ACC: one operand per cycle.
- Latency: out_valid rises N cycles after the clock edge that accepted the in_last operand (4 cycles at defaults).
- Output handshake completes on an edge where out_valid && out_ready. in_ready rises the following cycle, giving one bubble between frames. There is no accept/emit overlap.
- out_ready held high before OUT is entered: the handshake happens in the first OUT cycle.
- in_last on the first operand of a frame: single-operand frame, result = operand.
- Counter saturation affects only out_count; the sum continues to accumulate.
- rst_n asserted in any state, including mid-RESOLVE or OUT: immediate return to reset values. No partial result is emitted. The next frame starts clean.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_count=0. After release, in_ready=1.
- Frame 0x10, 0x20, 0x30 (last) back-to-back, out_ready=1 -> out_data=0x0060 and out_count=3. out_valid rises 4 cycles after the last accept, high for 1 cycle. in_ready returns 1 cycle later.
- 300 operands of 0xFF with random in_valid gaps -> out_data=0x2AD4 (76500 mod 65536) and out_count=255. Gap cycles do not change the sum.
- Single operand 0xAB with in_last=1 -> out_data=0x00AB, out_count=1.
- Backpressure: frame 0xFF, 0x01 (last) with out_ready=0 for 10 cycles -> out_valid stays 1 with out_data=0x0100 stable. in_ready=0 throughout, and in_valid pulses are ignored. Release out_ready -> ACC next cycle.
- Reset mid-RESOLVE: assert rst_n=0 two cycles after the last accept -> no out_valid. The following frame 0x05, 0x07 (last) gives out_data=0x000C, out_count=2.
